// File: rtl/shift_add_mult_ctrl.sv
// Sequential 32x32 -> 64-bit unsigned shift-and-add multiplier that reuses one ripple adder
// once per clock, with a start/busy/done handshake toward upstream control.

module ripple_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             ci,
  output logic [WIDTH-1:0] s,
  output logic             co
);

  logic [WIDTH:0] carry_s;

  assign carry_s[0] = ci;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign s[i]         = x[i] ^ y[i] ^ carry_s[i];
    assign carry_s[i+1] = (x[i] & y[i]) | (carry_s[i] & (x[i] ^ y[i]));
  end

  assign co = carry_s[WIDTH];

endmodule

module shift_add_mult_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0] acc_hi_r;
  logic [WIDTH-1:0] mq_r;
  logic [CW-1:0]    count_r;
  logic             busy_r;
  logic             done_r;
  logic             load_s;
  logic             shift_s;
  logic [WIDTH-1:0] addend_s;
  logic [WIDTH-1:0] sum_s;
  logic             co_s;

  // The partial product only grows by mcand when the current multiplier LSB is set.
  assign addend_s = mq_r[0] ? mcand_r : {WIDTH{1'b0}};

  ripple_adder #(.WIDTH(WIDTH)) u_adder (
    .x  (acc_hi_r),
    .y  (addend_s),
    .ci (1'b0),
    .s  (sum_s),
    .co (co_s)
  );

  // Next-state decode; a start in DONE is accepted just like one in IDLE.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    shift_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          load_s      = 1'b1;
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        shift_s = 1'b1;
        if (count_r == CW'(WIDTH - 1)) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE: begin
        if (start) begin
          load_s      = 1'b1;
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, handshake flags and datapath registers; the carry-out becomes the new acc_hi MSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      mcand_r  <= {WIDTH{1'b0}};
      acc_hi_r <= {WIDTH{1'b0}};
      mq_r     <= {WIDTH{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == RUN);
      done_r  <= (state_nxt_s == DONE);
      if (load_s) begin
        mcand_r  <= a;
        mq_r     <= b;
        acc_hi_r <= {WIDTH{1'b0}};
        count_r  <= {CW{1'b0}};
      end else if (shift_s) begin
        {acc_hi_r, mq_r} <= {co_s, sum_s, mq_r[WIDTH-1:1]};
        count_r          <= count_r + {{(CW-1){1'b0}}, 1'b1};
      end
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign product = {acc_hi_r, mq_r};

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Scoreboard bench for shift_add_mult_ctrl: a driver pushes expected products and done times,
// a monitor compares them whenever the DUT reports done.

module tb_shift_add_mult_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] product;

  typedef struct {
    logic [63:0] prod;
    int          done_edge;
  } exp_t;

  exp_t        exp_q[$];
  int          edge_cnt  = 0;
  int          next_free = 0;
  logic [63:0] last_prod = 64'd0;
  int          n_pass    = 0;
  int          n_total   = 0;
  int          n_ops     = 0;

  shift_add_mult_ctrl #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_cnt);
  endtask

  // Drive one cycle; the model accepts a start only when no operation occupies the block.
  task automatic drive(input logic st, input logic [31:0] av, input logic [31:0] bv);
    exp_t e;
    int   nxt;
    @(negedge clk);
    start = st;
    a     = av;
    b     = bv;
    nxt   = edge_cnt + 1;
    if (st && !rst && nxt >= next_free) begin
      e.prod      = 64'(av) * 64'(bv);
      e.done_edge = nxt + 32;
      exp_q.push_back(e);
      next_free   = nxt + 33;
      n_ops++;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 80 && exp_q.size() != 0; i++) drive(1'b0, $urandom, $urandom);
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: compare after every edge against the scoreboard front.
  always @(posedge clk) begin
    logic exp_busy;
    logic exp_done;
    edge_cnt++;
    #1;
    exp_done = (exp_q.size() != 0) && (exp_q[0].done_edge == edge_cnt);
    exp_busy = (exp_q.size() != 0) && (edge_cnt >= exp_q[0].done_edge - 32) &&
               (edge_cnt < exp_q[0].done_edge);
    if (busy && done) check("busy_and_done", {62'd0, busy, done}, 64'd0);
    check("done", 64'(done), 64'(exp_done));
    check("busy", 64'(busy), 64'(exp_busy));
    if (exp_done) begin
      if (done) check("product", product, exp_q[0].prod);
      last_prod = exp_q[0].prod;
      void'(exp_q.pop_front());
    end else if (!exp_busy) begin
      check("product_hold", product, last_prod);
    end
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = 32'd0;
    b     = 32'd0;
    #12;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_product", product, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    drive(1'b1, 32'd3, 32'd5);
    drain();
    drive(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    drain();
    drive(1'b1, 32'h1234_5678, 32'd0);
    drain();
    drive(1'b1, 32'd0, 32'hDEAD_BEEF);
    drain();

    for (int i = 0; i < 99; i++) drive(1'b1, 32'd7, 32'd9);
    drain();

    drive(1'b1, 32'd2, 32'd3);
    for (int i = 0; i < 10; i++) drive(1'b0, 32'd2, 32'd3);
    drive(1'b1, 32'd99, 32'd77);
    drain();

    // Asynchronous reset in the middle of an operation.
    drive(1'b1, 32'd100, 32'd200);
    for (int i = 0; i < 10; i++) drive(1'b0, $urandom, $urandom);
    @(negedge clk);
    #2;
    rst = 1'b1;
    exp_q.delete();
    next_free = 0;
    last_prod = 64'd0;
    #1;
    check("midrun_rst_busy", 64'(busy), 64'd0);
    check("midrun_rst_done", 64'(done), 64'd0);
    check("midrun_rst_product", product, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 32'd100, 32'd200);
    drain();
    check("after_rst_product", product, 64'd20000);

    while (n_ops < 1020) begin
      drive(($urandom_range(3, 0) != 0), $urandom, $urandom);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
